// File: rtl/nibble_serial_incr_ctrl.sv
// Wide +1 built from one 4-bit incrementer slice reused over several cycles,
// LSB nibble first. Define NIBBLE_INCR_EARLY_EXIT_EN to stop once the carry dies.
module nibble_serial_incr_ctrl #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] operand,
  input  logic             clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carryOutput,
  output logic             busy,
  output logic [1:0]       o_dbg_state
);

  localparam int NUM_NIB = WIDTH / 4;
  localparam int IDX_W   = (NUM_NIB > 1) ? $clog2(NUM_NIB) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_NIB - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Handshakes: a transfer happens on a rising edge where valid && ready.
  // in_ready is high only in IDLE; out_valid is high only in DONE, and the
  // result is held stable until out_ready. clear overrides both.

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_work;
  logic [WIDTH-1:0] w_work_nxt;
  logic [IDX_W-1:0] r_idx;
  logic             r_carry;
  logic             w_carry_nxt;
  logic [WIDTH-1:0] r_result;
  logic             r_carry_out;
  logic [3:0]       w_nib;
  logic [3:0]       w_slice_sum;
  logic             w_slice_co;
  logic             w_last;
  logic             w_exit;
  logic             w_accept;
  logic             w_finish;

  // Single shared slice: select nibble r_idx, add one, write it back only
  // while the rippled carry is still alive.
  always_comb begin
    w_nib = '0;
    for (int n = 0; n < NUM_NIB; n++) begin
      if (r_idx == IDX_W'(n)) begin
        w_nib = r_work[n*4 +: 4];
      end
    end
    {w_slice_co, w_slice_sum} = {1'b0, w_nib} + 5'd1;
    w_work_nxt  = r_work;
    w_carry_nxt = r_carry;
    if (r_carry) begin
      for (int n = 0; n < NUM_NIB; n++) begin
        if (r_idx == IDX_W'(n)) begin
          w_work_nxt[n*4 +: 4] = w_slice_sum;
        end
      end
      w_carry_nxt = w_slice_co;
    end
  end

  assign w_last = (r_idx == LAST_IDX);

`ifdef NIBBLE_INCR_EARLY_EXIT_EN
  assign w_exit = w_last || !w_carry_nxt;
`else
  assign w_exit = w_last;
`endif

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_finish    = 1'b0;
    if (clear) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_exit) begin
            w_finish    = 1'b1;
            w_state_nxt = ST_DONE;
          end
        end
        ST_DONE: begin
          if (out_ready) begin
            w_state_nxt = ST_IDLE;
          end
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_work      <= '0;
      r_idx       <= '0;
      r_carry     <= 1'b0;
      r_result    <= '0;
      r_carry_out <= 1'b0;
    end else begin
      if (w_accept) begin
        r_work  <= operand;
        r_idx   <= '0;
        r_carry <= 1'b1;
      end else if (r_state == ST_RUN && !clear) begin
        r_work  <= w_work_nxt;
        r_carry <= w_carry_nxt;
        r_idx   <= r_idx + 1'b1;
      end
      // Result registers only move on the finishing edge, so a clear leaves
      // the previous result visible.
      if (w_finish) begin
        r_result    <= w_work_nxt;
        r_carry_out <= w_carry_nxt;
      end
    end
  end

  assign in_ready    = (r_state == ST_IDLE);
  assign out_valid   = (r_state == ST_DONE);
  assign busy        = (r_state == ST_RUN) || (r_state == ST_DONE);
  assign result      = r_result;
  assign carryOutput = r_carry_out;
  assign o_dbg_state = r_state;

endmodule

// File: doc/nibble_serial_incr_ctrl.md
Name: nibble_serial_incr_ctrl

Overview:
- Sequencer that increments a WIDTH-bit operand by one.
- Reuses a single 4-bit incrementer slice (nibble + 1, with carry-out) over several cycles, one nibble per cycle, starting at the LSB.
- Carry is rippled across cycles in a register.
- Sits between a requester (valid/ready) and a consumer (valid/ready) wherever a wide increment is needed without a wide adder.

Parameters:
- WIDTH, 16: operand/result width in bits. Must be a multiple of 4 and at least 4. NUM_NIB = WIDTH/4 is a derived localparam.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  operand offered.
- in_ready  out  1  block can accept an operand (high only in IDLE).
- operand  in  WIDTH  value to increment; sampled on acceptance.
- clear  in  1  synchronous abort: return to IDLE and discard any work.
- out_valid  out  1  result and carryOutput are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  operand + 1, modulo 2^WIDTH.
- carryOutput  out  1  high when operand was all ones (wrap to 0).
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, carryOutput=0, nibble index=0, carry register=0.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid: load operand into a working register, set nibble index=0, set carry register=1, go to RUN.
  - That edge is the acceptance edge.
- RUN, one nibble per cycle at index i:
  - If the carry register is 1: nibble i is replaced by the slice output, and the carry register takes the slice carry-out.
  - If the carry register is 0: nibble i is left unchanged.
  - Then i increments.
- Exit from RUN: go to DONE on the edge that processes nibble NUM_NIB-1, or earlier per Optional Feature.
- Entering DONE:
  - result = working register; carryOutput = carry register; out_valid=1.
  - Untouched upper nibbles equal the operand's.
- DONE: result and carryOutput are held stable while out_valid=1 and out_ready=0. On out_ready=1, go to IDLE and set out_valid=0.
- Latency: out_valid rises k edges after the acceptance edge, where k is the number of nibbles processed (1 to NUM_NIB).
- Throughput: one operation per k+2 cycles at best. in_ready is low throughout RUN and DONE, so a new operand can never be accepted in the same cycle a result is consumed.
- in_valid while busy: ignored; the operand is not sampled.
- clear:
  - Takes priority over all other inputs in every state: next state=IDLE, out_valid=0.
  - result and carryOutput keep their last values.
  - An in_valid in the same cycle as clear is not accepted.
- Wrap-around: operand all ones gives result=0, carryOutput=1. carryOutput is 0 for any other operand.
- Reset mid-operation: immediate return to the reset values above; the partial result is lost.
- WIDTH=4: single RUN cycle, k=1.

Optional Feature:
- Macro: NIBBLE_INCR_EARLY_EXIT_EN.
- Defined:
  - RUN also exits to DONE on the edge where the carry register becomes 0.
  - k = 1 + index of the lowest nibble not equal to 0xF, capped at NUM_NIB.
- Undefined:
  - Fixed latency k=NUM_NIB. Nibbles after the carry dies pass through unchanged.
  - result and carryOutput are identical to the defined case.

Test Plan (WIDTH=16):
- operand 0x1234, out_ready=1:
  - Result 0x1235, carryOutput=0.
  - out_valid 1 edge after acceptance with NIBBLE_INCR_EARLY_EXIT_EN, 4 edges without.
- operand 0x12FF: result 0x1300, carryOutput=0; k=3 with the macro, 4 without.
- operand 0xFFFF: result 0x0000, carryOutput=1, k=4. Then operand 0x0000: result 0x0001, carryOutput=0.
- operand 0x00FF, out_ready held 0 for 5 cycles after out_valid:
  - result stays 0x0100; in_ready=0 and busy=1 throughout.
  - in_valid with 0xAAAA during this window is not accepted.
  - After out_ready=1: IDLE, in_ready=1.
- operand 0xFFF0 under two abort cases:
  - clear pulsed one cycle after acceptance: next state IDLE, out_valid never rises.
  - rst_n low mid-RUN: all outputs at reset values asynchronously.
  - A following 0x0007 yields 0x0008.
